// File: rtl/rv32_mc_ctrl.sv
// Multi-cycle RV32 control FSM: fetch/decode/exec/mem/wb sequencing, imm select, retire counter.
// Optional ack-wait watchdog with sticky timeout output when RV32_MC_CTRL_TIMEOUT_EN is defined.
package rv32_pkg;
  typedef enum logic [2:0] {
    Imm_I = 3'd0,
    Imm_S = 3'd1,
    Imm_B = 3'd2,
    Imm_U = 3'd3,
    Imm_J = 3'd4
  } ImmSel_t;
endpackage

module rv32_mc_ctrl
  import rv32_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      inst,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  input  logic             br_taken,
  output ImmSel_t          imm_sel,
  output logic             imem_req,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             alu_src_b,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
`ifdef RV32_MC_CTRL_TIMEOUT_EN
  ,
  output logic             timeout
`endif
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  state_t     state, state_nxt;
  logic [6:0] opc_q;
  logic [6:0] opc;
  logic       legal;
  logic       retire;
  logic       trap_set;
  logic       illegal_q;
  logic       unused_bits;

  // DECODE sees the opcode before it is latched, so select it straight from the IR.
  assign opc = (state == S_DECODE) ? inst[6:0] : opc_q;

  always_comb begin
    legal     = 1'b1;
    imm_sel   = Imm_I;
    alu_src_b = 1'b1;
    case (opc)
      OP_LOAD, OP_IMM, OP_JALR: imm_sel = Imm_I;
      OP_STORE:                 imm_sel = Imm_S;
      OP_BRANCH: begin
        imm_sel   = Imm_B;
        alu_src_b = 1'b0;
      end
      OP_LUI, OP_AUIPC:         imm_sel = Imm_U;
      OP_JAL:                   imm_sel = Imm_J;
      OP_REG:                   alu_src_b = 1'b0;
      default: begin
        legal     = 1'b0;
        alu_src_b = 1'b0;
      end
    endcase
  end

`ifdef RV32_MC_CTRL_TIMEOUT_EN
  localparam int WAIT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  logic [WAIT_W-1:0] wait_cnt;
  logic              tmo;
  logic              tmo_set;
  logic              timeout_q;

  assign tmo = (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 2'd0;
    rf_we     = 1'b0;
    wb_sel    = 2'd0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    retire    = 1'b0;
    trap_set  = 1'b0;
`ifdef RV32_MC_CTRL_TIMEOUT_EN
    tmo_set   = 1'b0;
`endif
    case (state)
      S_IDLE: state_nxt = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we     = 1'b1;
          state_nxt = S_DECODE;
        end
`ifdef RV32_MC_CTRL_TIMEOUT_EN
        else if (tmo) begin
          state_nxt = S_TRAP;
          trap_set  = 1'b1;
          tmo_set   = 1'b1;
        end
`endif
      end
      S_DECODE: begin
        if (legal) begin
          state_nxt = S_EXEC;
        end else begin
          state_nxt = S_TRAP;
          trap_set  = 1'b1;
        end
      end
      S_EXEC: begin
        if (opc_q == OP_LOAD || opc_q == OP_STORE) begin
          state_nxt = S_MEM;
        end else if (opc_q == OP_BRANCH) begin
          pc_we     = 1'b1;
          pc_src    = br_taken ? 2'd1 : 2'd0;
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opc_q == OP_STORE);
        if (dmem_ack) begin
          if (opc_q == OP_STORE) begin
            pc_we     = 1'b1;
            retire    = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_WB;
          end
        end
`ifdef RV32_MC_CTRL_TIMEOUT_EN
        else if (tmo) begin
          state_nxt = S_TRAP;
          trap_set  = 1'b1;
          tmo_set   = 1'b1;
        end
`endif
      end
      S_WB: begin
        rf_we     = (inst[11:7] != 5'd0);
        pc_we     = 1'b1;
        wb_sel    = (opc_q == OP_LOAD) ? 2'd1 :
                    (opc_q == OP_JAL || opc_q == OP_JALR) ? 2'd2 : 2'd0;
        pc_src    = (opc_q == OP_JAL) ? 2'd1 : (opc_q == OP_JALR) ? 2'd2 : 2'd0;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_TRAP: state_nxt = S_TRAP;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      opc_q     <= 7'd0;
      instret   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) opc_q <= inst[6:0];
      if (retire) instret <= instret + 1'b1;
      if (trap_set) illegal_q <= 1'b1;
    end
  end

  assign illegal = illegal_q;

`ifdef RV32_MC_CTRL_TIMEOUT_EN
  // Counter restarts whenever a wait state is freshly entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_nxt != state) wait_cnt <= '0;
      else if ((state == S_FETCH && !imem_ack) || (state == S_MEM && !dmem_ack))
        wait_cnt <= wait_cnt + 1'b1;
      if (tmo_set) timeout_q <= 1'b1;
    end
  end

  assign timeout     = timeout_q;
  assign unused_bits = ^inst[31:12];
`else
  localparam logic [31:0] TMO_L = 32'(TIMEOUT_CYCLES);
  assign unused_bits = ^{inst[31:12], TMO_L};
`endif

endmodule

// File: tb/tb_rv32_mc_ctrl.sv
// Bench for rv32_mc_ctrl: directed instruction table plus random instruction stream vs per-instruction trace model.
module tb_rv32_mc_ctrl;
  import rv32_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst = 32'd0;
  logic        imem_ack = 1'b0, dmem_ack = 1'b0, br_taken = 1'b0;
  ImmSel_t     imm_sel;
  logic        imem_req, ir_we, pc_we, rf_we, dmem_req, dmem_we, alu_src_b, illegal;
  logic [1:0]  pc_src, wb_sel;
  logic [31:0] instret;

  always #5 clk = ~clk;

  rv32_mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .br_taken(br_taken), .imm_sel(imm_sel), .imem_req(imem_req), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .rf_we(rf_we), .wb_sel(wb_sel), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .alu_src_b(alu_src_b), .illegal(illegal), .instret(instret)
  );

  typedef struct packed {
    logic       imem_req, ir_we, pc_we;
    logic [1:0] pc_src;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       dmem_req, dmem_we, asb;
    logic [2:0] imm;
    logic       illegal;
  } obs_t;

  typedef struct {
    logic        ia, da, br;
    obs_t        e;
    logic [31:0] cnt;
    logic        dec;
  } cyc_t;

  typedef struct {
    logic [31:0] inst;
    int          idly, ddly;
    logic        br;
    logic [2:0]  exp_imm;
    int          exp_rf;
  } vec_t;

  cyc_t        tr[$];
  int          total = 0, bad = 0;
  logic [6:0]  last_op;
  logic [31:0] m_cnt;

  function automatic logic is_legal(input logic [6:0] op);
    return op inside {7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    case (op)
      7'h23:        return 3'(Imm_S);
      7'h63:        return 3'(Imm_B);
      7'h37, 7'h17: return 3'(Imm_U);
      7'h6F:        return 3'(Imm_J);
      default:      return 3'(Imm_I);
    endcase
  endfunction

  // Values visible in every cycle: immediate select and operand-B select of the given opcode.
  function automatic obs_t base(input logic [6:0] op);
    obs_t o;
    o     = '0;
    o.imm = imm_of(op);
    o.asb = is_legal(op) && op != 7'h33 && op != 7'h63;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.imem_req = imem_req; o.ir_we = ir_we; o.pc_we = pc_we; o.pc_src = pc_src;
    o.rf_we = rf_we; o.wb_sel = wb_sel; o.dmem_req = dmem_req; o.dmem_we = dmem_we;
    o.asb = alu_src_b; o.imm = 3'(imm_sel); o.illegal = illegal;
    return o;
  endfunction

  function automatic cyc_t mk(input obs_t e, input logic [31:0] cnt);
    cyc_t c;
    c.ia = 1'($urandom); c.da = 1'($urandom); c.br = 1'($urandom);
    c.e = e; c.cnt = cnt; c.dec = 1'b0;
    return c;
  endfunction

  // Expected per-cycle trace of one instruction, from its first FETCH cycle to the last cycle before the next.
  task automatic build(input logic [31:0] ins, input int idly, input int ddly, input logic br);
    logic [6:0] op;
    cyc_t       c;
    op = ins[6:0];
    for (int k = 0; k <= idly; k++) begin
      c = mk(base(last_op), m_cnt);
      c.ia = (k == idly);
      c.e.imem_req = 1'b1;
      c.e.ir_we = (k == idly);
      tr.push_back(c);
    end
    c = mk(base(op), m_cnt);
    c.dec = 1'b1;
    tr.push_back(c);
    last_op = op;
    if (!is_legal(op)) begin
      for (int k = 0; k < 20; k++) begin
        c = mk(base(op), m_cnt);
        c.e.illegal = 1'b1;
        tr.push_back(c);
      end
      return;
    end
    c = mk(base(op), m_cnt);
    if (op == 7'h63) begin
      c.br = br;
      c.e.pc_we = 1'b1;
      c.e.pc_src = br ? 2'd1 : 2'd0;
      tr.push_back(c);
      m_cnt++;
      return;
    end
    tr.push_back(c);
    if (op == 7'h03 || op == 7'h23) begin
      for (int k = 0; k <= ddly; k++) begin
        c = mk(base(op), m_cnt);
        c.da = (k == ddly);
        c.e.dmem_req = 1'b1;
        c.e.dmem_we = (op == 7'h23);
        c.e.pc_we = (k == ddly) && (op == 7'h23);
        tr.push_back(c);
      end
      if (op == 7'h23) begin
        m_cnt++;
        return;
      end
    end
    c = mk(base(op), m_cnt);
    c.e.rf_we = (ins[11:7] != 5'd0);
    c.e.pc_we = 1'b1;
    c.e.wb_sel = (op == 7'h03) ? 2'd1 : (op == 7'h6F || op == 7'h67) ? 2'd2 : 2'd0;
    c.e.pc_src = (op == 7'h6F) ? 2'd1 : (op == 7'h67) ? 2'd2 : 2'd0;
    tr.push_back(c);
    m_cnt++;
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic run(input string name, input int limit, output int rf_cnt, output logic [2:0] dec_imm);
    cyc_t c;
    obs_t got;
    int   n;
    rf_cnt = 0; dec_imm = '0; n = 0;
    while (tr.size() > 0 && n < limit) begin
      c = tr.pop_front();
      imem_ack = c.ia; dmem_ack = c.da; br_taken = c.br;
      @(negedge clk);
      got = sample();
      total++;
      if (got !== c.e || instret !== c.cnt) begin
        bad++;
        $display("FAIL %s cyc%0d: got outs=%h instret=%0d, want outs=%h instret=%0d",
                 name, n, got, instret, c.e, c.cnt);
      end
      if (rf_we) rf_cnt++;
      if (c.dec) dec_imm = 3'(imm_sel);
      @(posedge clk); #1;
      n++;
    end
    tr.delete();
  endtask

  task automatic do_reset();
    obs_t want;
    rst_n = 1'b0;
    @(posedge clk); #1;
    want = base(7'h00);
    total++;
    if (sample() !== want || instret !== 32'd0) begin
      bad++;
      $display("FAIL reset_hold: got outs=%h instret=%0d, want outs=%h instret=0", sample(), instret, want);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    imem_ack = 1'b1;
    last_op = 7'h00;
    m_cnt = 32'd0;
    @(negedge clk);
    total++;
    if (sample() !== want) begin
      bad++;
      $display("FAIL idle: got outs=%h, want outs=%h", sample(), want);
    end
    @(posedge clk); #1;
  endtask

  vec_t        vecs[10];
  int          rfc;
  logic [2:0]  dimm;
  logic [6:0]  ops[9];
  logic [31:0] r;

  initial begin
    vecs[0] = '{32'h00500093, 2, 0, 1'b0, 3'(Imm_I), 1};
    vecs[1] = '{32'h0020A423, 0, 3, 1'b0, 3'(Imm_S), 0};
    vecs[2] = '{32'h00208463, 0, 0, 1'b1, 3'(Imm_B), 0};
    vecs[3] = '{32'h00208463, 0, 0, 1'b0, 3'(Imm_B), 0};
    vecs[4] = '{32'h010000EF, 0, 0, 1'b0, 3'(Imm_J), 1};
    vecs[5] = '{32'h0100006F, 1, 0, 1'b0, 3'(Imm_J), 0};
    vecs[6] = '{32'h0040A183, 1, 2, 1'b0, 3'(Imm_I), 1};
    vecs[7] = '{32'h123452B7, 0, 0, 1'b0, 3'(Imm_U), 1};
    vecs[8] = '{32'h000100E7, 3, 0, 1'b0, 3'(Imm_I), 1};
    vecs[9] = '{32'h002081B3, 0, 0, 1'b0, 3'(Imm_I), 1};
    ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};

    do_reset();

    foreach (vecs[i]) begin
      inst = vecs[i].inst;
      build(vecs[i].inst, vecs[i].idly, vecs[i].ddly, vecs[i].br);
      run($sformatf("vec%0d", i), 1000, rfc, dimm);
      total++;
      if (dimm !== vecs[i].exp_imm || rfc != vecs[i].exp_rf) begin
        bad++;
        $display("FAIL vec%0d_summary: got imm=%0d rf_pulses=%0d, want imm=%0d rf_pulses=%0d",
                 i, dimm, rfc, vecs[i].exp_imm, vecs[i].exp_rf);
      end
    end

    for (int i = 0; i < 150; i++) begin
      r = $urandom;
      r[6:0] = ops[$urandom_range(0, 8)];
      inst = r;
      build(r, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
      run($sformatf("rnd%0d", i), 1000, rfc, dimm);
    end

    // Reset landing in the middle of a stalled store.
    inst = 32'h0020A423;
    build(inst, 0, 10, 1'b0);
    run("mid_reset_pre", 4, rfc, dimm);
    dmem_ack = 1'b0;
    rst_n = 1'b0;
    #1;
    total++;
    if (dmem_req !== 1'b0 || instret !== 32'd0 || illegal !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: got dmem_req=%b instret=%0d illegal=%b, want 0 0 0",
               dmem_req, instret, illegal);
    end
    do_reset();

    // Illegal opcode traps and stays there until reset.
    inst = 32'hFFFFFFFF;
    build(inst, 0, 0, 1'b0);
    run("trap", 1000, rfc, dimm);
    do_reset();
    total++;
    if (illegal !== 1'b0 || imem_req !== 1'b1) begin
      bad++;
      $display("FAIL post_trap_reset: got illegal=%b imem_req=%b, want illegal=0 imem_req=1",
               illegal, imem_req);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, want completion");
    $fatal(1, "watchdog");
  end

endmodule
